// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//
// ID/EX pipeline register sitting directly in front of the ALU. Each accepted
// instruction is decoded (aluop/funct -> 4-bit ALU operation), its operands
// are selected (register value, forwarded value or extended immediate) and
// everything is registered so the ALU sees stable data0/data1/operation on
// its own clock edge. Latency is one cycle.
//
// Configuration macro:
//   ALU_OPERAND_FWD_EN  defined   : EX/MEM and MEM/WB results are forwarded
//                                   onto rs/rt (EX/MEM has priority, r0 never
//                                   forwarded).
//                       undefined : operands come straight from the register
//                                   file; ex_mem_* / mem_wb_* are ignored.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_valid / in_ready             input handshake (in_ready = !stall)
//   stall, flush                    hold all outputs / insert a bubble
//   rs_addr, rt_addr, rd_addr       register indices (rd passed through)
//   rs_data, rt_data                register-file read values
//   imm, sign_ext, alu_src          immediate and its use for operand 1
//   aluop, funct                    operation select
//   ex_mem_*, mem_wb_*              forwarding sources
//   out_valid, data0, data1,
//   operation, store_data,
//   dest_reg, illegal_op            registered outputs to the ALU
// ---------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm,
    input  logic              sign_ext,
    input  logic              alu_src,
    input  logic [1:0]        aluop,
    input  logic [5:0]        funct,
    input  logic              ex_mem_wr_en,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic [DATA_W-1:0] ex_mem_result,
    input  logic              mem_wb_wr_en,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic [DATA_W-1:0] mem_wb_result,
    output logic              out_valid,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    output logic [3:0]        operation,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_AW-1:0] dest_reg,
    output logic              illegal_op
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;

    // ---------------- decode ----------------
    logic [3:0] op_next;
    logic       illegal_next;

    always_comb begin
        op_next      = OP_ADD;
        illegal_next = 1'b0;
        case (aluop)
            2'b00: op_next = OP_ADD;
            2'b01: op_next = OP_SUB;
            2'b11: op_next = OP_OR;
            default: begin
                case (funct)
                    6'b100000: op_next = OP_ADD;
                    6'b100010: op_next = OP_SUB;
                    6'b100100: op_next = OP_AND;
                    6'b100101: op_next = OP_OR;
                    6'b101010: op_next = OP_SLT;
                    6'b100111: op_next = OP_NOR;
                    default: begin
                        op_next      = OP_ADD;
                        illegal_next = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // ---------------- immediate extension ----------------
    logic [DATA_W-1:0] imm_ext;
    assign imm_ext = sign_ext ? {{(DATA_W-16){imm[15]}}, imm}
                              : {{(DATA_W-16){1'b0}}, imm};

    // ---------------- operand forwarding ----------------
    // Index 0 is rs, index 1 is rt.
    logic [REG_AW-1:0] src_addr [2];
    logic [DATA_W-1:0] src_data [2];
    logic [DATA_W-1:0] fwd_data [2];

    assign src_addr[0] = rs_addr;
    assign src_addr[1] = rt_addr;
    assign src_data[0] = rs_data;
    assign src_data[1] = rt_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
`ifdef ALU_OPERAND_FWD_EN
            // The younger result (EX/MEM) wins over MEM/WB; r0 is hard-wired
            // zero in the register file, so a write to it must never leak.
            always_comb begin
                fwd_data[gi] = src_data[gi];
                if (src_addr[gi] != '0) begin
                    if (ex_mem_wr_en && (ex_mem_rd == src_addr[gi]))
                        fwd_data[gi] = ex_mem_result;
                    else if (mem_wb_wr_en && (mem_wb_rd == src_addr[gi]))
                        fwd_data[gi] = mem_wb_result;
                end
            end
`else
            assign fwd_data[gi] = src_data[gi];
`endif
        end
    endgenerate

`ifndef ALU_OPERAND_FWD_EN
    // Forwarding inputs have no function in this build.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = &{1'b0, ex_mem_wr_en, ex_mem_rd, ex_mem_result,
                                 mem_wb_wr_en, mem_wb_rd, mem_wb_result,
                                 rs_addr, rt_addr};
`endif

    // ---------------- pipeline register ----------------
    logic              valid_reg;
    logic [DATA_W-1:0] data0_reg;
    logic [DATA_W-1:0] data1_reg;
    logic [3:0]        op_reg;
    logic [DATA_W-1:0] store_reg;
    logic [REG_AW-1:0] dest_reg_q;
    logic              illegal_reg;

    assign in_ready = !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg   <= 1'b0;
            data0_reg   <= '0;
            data1_reg   <= '0;
            op_reg      <= OP_ADD;
            store_reg   <= '0;
            dest_reg_q  <= '0;
            illegal_reg <= 1'b0;
        end else if (flush) begin
            // Bubble: operand registers keep their contents.
            valid_reg   <= 1'b0;
            op_reg      <= OP_ADD;
            illegal_reg <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                valid_reg   <= 1'b1;
                data0_reg   <= fwd_data[0];
                data1_reg   <= alu_src ? imm_ext : fwd_data[1];
                op_reg      <= op_next;
                store_reg   <= fwd_data[1];
                dest_reg_q  <= rd_addr;
                illegal_reg <= illegal_next;
            end else begin
                // Idle bubble; illegal_op only ever accompanies a valid output.
                valid_reg   <= 1'b0;
                illegal_reg <= 1'b0;
            end
        end
    end

    assign out_valid  = valid_reg;
    assign data0      = data0_reg;
    assign data1      = data1_reg;
    assign operation  = op_reg;
    assign store_data = store_reg;
    assign dest_reg   = dest_reg_q;
    assign illegal_op = illegal_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Directed and randomized stimulus for alu_operand_stage, compared every cycle
// against a behavioural model of the stage. Honours ALU_OPERAND_FWD_EN the
// same way the design does.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush;
    logic        in_ready;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic        sign_ext, alu_src;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        ex_mem_wr_en, mem_wb_wr_en;
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic [31:0] ex_mem_result, mem_wb_result;
    logic        out_valid, illegal_op;
    logic [31:0] data0, data1, store_data;
    logic [3:0]  operation;
    logic [4:0]  dest_reg;

    int errors = 0;
    int checks = 0;

    // model state
    logic        m_valid, m_ill;
    logic [31:0] m_d0, m_d1, m_sd;
    logic [3:0]  m_op;
    logic [4:0]  m_dest;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rd_addr(rd_addr), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .sign_ext(sign_ext), .alu_src(alu_src), .aluop(aluop), .funct(funct),
        .ex_mem_wr_en(ex_mem_wr_en), .ex_mem_rd(ex_mem_rd),
        .ex_mem_result(ex_mem_result), .mem_wb_wr_en(mem_wb_wr_en),
        .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result),
        .out_valid(out_valid), .data0(data0), .data1(data1),
        .operation(operation), .store_data(store_data), .dest_reg(dest_reg),
        .illegal_op(illegal_op)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Operation table of the ALU: returns {illegal, op}.
    function automatic logic [4:0] ref_decode(input logic [1:0] a, input logic [5:0] f);
        if (a == 2'd0) return {1'b0, 4'd2};
        if (a == 2'd1) return {1'b0, 4'd6};
        if (a == 2'd3) return {1'b0, 4'd1};
        if (f == 6'd32) return {1'b0, 4'd2};   // add
        if (f == 6'd34) return {1'b0, 4'd6};   // sub
        if (f == 6'd36) return {1'b0, 4'd0};   // and
        if (f == 6'd37) return {1'b0, 4'd1};   // or
        if (f == 6'd42) return {1'b0, 4'd7};   // slt
        if (f == 6'd39) return {1'b0, 4'd12};  // nor
        return {1'b1, 4'd2};
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] rf);
`ifdef ALU_OPERAND_FWD_EN
        if (a != 0 && ex_mem_wr_en && ex_mem_rd == a) return ex_mem_result;
        if (a != 0 && mem_wb_wr_en && mem_wb_rd == a) return mem_wb_result;
`endif
        return rf;
    endfunction

    // Advance one clock: check in_ready, update the model from the current
    // inputs, then compare every registered output after the edge.
    task automatic tick();
        logic [4:0]  dec;
        logic [31:0] ext;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, !stall});
        dec = ref_decode(aluop, funct);
        ext = sign_ext ? {{16{imm[15]}}, imm} : {16'd0, imm};
        if (reset) begin
            m_valid = 0; m_d0 = 0; m_d1 = 0; m_sd = 0; m_op = 2; m_dest = 0; m_ill = 0;
        end else if (flush) begin
            m_valid = 0; m_op = 2; m_ill = 0;
        end else if (!stall) begin
            if (in_valid) begin
                m_valid = 1;
                m_d0    = ref_fwd(rs_addr, rs_data);
                m_sd    = ref_fwd(rt_addr, rt_data);
                m_d1    = alu_src ? ext : m_sd;
                m_op    = dec[3:0];
                m_ill   = dec[4];
                m_dest  = rd_addr;
            end else begin
                m_valid = 0; m_ill = 0;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid",  {31'd0, out_valid},  {31'd0, m_valid});
        check("data0",      data0,               m_d0);
        check("data1",      data1,               m_d1);
        check("store_data", store_data,          m_sd);
        check("operation",  {28'd0, operation},  {28'd0, m_op});
        check("dest_reg",   {27'd0, dest_reg},   {27'd0, m_dest});
        check("illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
    endtask

    logic [5:0]  funct_tab [6];
    logic [31:0] snap_d0, snap_d1;
    logic [3:0]  snap_op;
    logic [3:0]  op_q [$];

    initial begin
        funct_tab[0] = 6'b100000; funct_tab[1] = 6'b100010; funct_tab[2] = 6'b100100;
        funct_tab[3] = 6'b100101; funct_tab[4] = 6'b101010; funct_tab[5] = 6'b100111;

        reset = 1; in_valid = 0; stall = 0; flush = 0;
        rs_addr = 1; rt_addr = 2; rd_addr = 3; rs_data = 0; rt_data = 0;
        imm = 0; sign_ext = 0; alu_src = 0; aluop = 0; funct = 0;
        ex_mem_wr_en = 0; ex_mem_rd = 0; ex_mem_result = 0;
        mem_wb_wr_en = 0; mem_wb_rd = 0; mem_wb_result = 0;
        m_valid = 0; m_d0 = 0; m_d1 = 0; m_sd = 0; m_op = 2; m_dest = 0; m_ill = 0;

        // reset for two cycles
        tick(); tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_op",    {28'd0, operation}, 32'd2);
        check("rst_data0", data0, 32'd0);
        check("rst_data1", data1, 32'd0);

        // R-type sub
        reset = 0; in_valid = 1; aluop = 2'b10; funct = 6'b100010;
        rs_data = 9; rt_data = 4; alu_src = 0;
        tick();
        check("sub_op",    {28'd0, operation}, 32'd6);
        check("sub_data0", data0, 32'd9);
        check("sub_data1", data1, 32'd4);
        check("sub_valid", {31'd0, out_valid}, 32'd1);
        funct = 6'b110000;
        tick();
        check("ill_flag", {31'd0, illegal_op}, 32'd1);
        check("ill_op",   {28'd0, operation}, 32'd2);

        // immediate extension
        aluop = 0; alu_src = 1; imm = 16'hFFFE; sign_ext = 1;
        tick();
        check("imm_sext", data1, 32'hFFFFFFFE);
        sign_ext = 0;
        tick();
        check("imm_zext", data1, 32'h0000FFFE);

        // forwarding
        alu_src = 0; rs_addr = 5; rs_data = 100;
        ex_mem_wr_en = 1; ex_mem_rd = 5; ex_mem_result = 7;
        mem_wb_wr_en = 1; mem_wb_rd = 5; mem_wb_result = 3;
        tick();
`ifdef ALU_OPERAND_FWD_EN
        check("fwd_exmem", data0, 32'd7);
`else
        check("fwd_exmem", data0, 32'd100);
`endif
        ex_mem_wr_en = 0;
        tick();
`ifdef ALU_OPERAND_FWD_EN
        check("fwd_memwb", data0, 32'd3);
`else
        check("fwd_memwb", data0, 32'd100);
`endif
        ex_mem_wr_en = 1; rs_addr = 0; ex_mem_rd = 0; mem_wb_rd = 0; rs_data = 55;
        tick();
        check("fwd_r0", data0, 32'd55);
        ex_mem_wr_en = 0; mem_wb_wr_en = 0;

        // stall for three cycles with changing inputs
        snap_d0 = data0; snap_d1 = data1; snap_op = operation;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rs_data = $urandom; rt_data = $urandom; aluop = 2'(i); rs_addr = 5'(i + 1);
            tick();
            check("stall_d0", data0, snap_d0);
            check("stall_d1", data1, snap_d1);
            check("stall_op", {28'd0, operation}, {28'd0, snap_op});
        end
        // stall + flush on the same edge
        flush = 1; aluop = 2'b01;
        tick();
        check("sf_valid", {31'd0, out_valid}, 32'd0);
        check("sf_op",    {28'd0, operation}, 32'd2);
        check("sf_d0",    data0, snap_d0);
        stall = 0; flush = 0;

        // back-to-back valid instructions
        in_valid = 1; aluop = 2'b10;
        for (int i = 0; i < 10; i++) begin
            funct = funct_tab[i % 6];
            op_q.push_back(ref_decode(aluop, funct) & 5'hF);
            tick();
            check("b2b_valid", {31'd0, out_valid}, 32'd1);
            check("b2b_op",    {28'd0, operation}, {28'd0, op_q.pop_front()});
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 99) < 3);
            flush    = ($urandom_range(0, 99) < 10);
            stall    = ($urandom_range(0, 99) < 20);
            in_valid = ($urandom_range(0, 99) < 80);
            rs_addr  = 5'($urandom_range(0, 3));
            rt_addr  = 5'($urandom_range(0, 3));
            rd_addr  = 5'($urandom);
            rs_data  = $urandom; rt_data = $urandom;
            imm      = 16'($urandom);
            sign_ext = 1'($urandom); alu_src = 1'($urandom);
            aluop    = 2'($urandom);
            funct    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : funct_tab[$urandom_range(0, 5)];
            ex_mem_wr_en = 1'($urandom); ex_mem_rd = 5'($urandom_range(0, 3));
            ex_mem_result = $urandom;
            mem_wb_wr_en = 1'($urandom); mem_wb_rd = 5'($urandom_range(0, 3));
            mem_wb_result = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
